// File: rtl/adc_conv_pkg.sv
// Shared types and field widths for the ADC conversion trigger.
// The optional conversion timeout is enabled with the ADC_CONV_TIMEOUT_EN macro.
package adc_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DLY_SHORT_W = 5;
    localparam int DLY_LONG_W  = 6;
    localparam int PULSE_W_W   = 6;

endpackage

// File: rtl/adc_sync_edge.sv
// Two-flop synchronizer for the asynchronous active-low conversion-done
// strobe, followed by a falling-edge detector on the synchronized level.
module adc_sync_edge
    import adc_conv_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_n_in,
    output logic fall_out
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], async_n_in};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Reset value 0 means the first rise after reset never looks like a fall.
    assign fall_out = prev_q & ~sync_q[1];

endmodule

// File: rtl/adc_conv_trigger.sv
// ADC conversion trigger: software/periodic start, enable + start pulse,
// result capture with valid/ready handshake and sticky overrun.
// Define ADC_CONV_TIMEOUT_EN to add the WAIT timeout and timeout_err_out.
module adc_conv_trigger
    import adc_conv_pkg::*;
#(
    parameter int RESULT_W    = 16,
    parameter int TIMEOUT_CYC = 1023,
    parameter int PERIOD_W    = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   sw_start_in,
    input  logic                   periodic_en_in,
    input  logic [PERIOD_W-1:0]    period_in,
    input  logic [PULSE_W_W-1:0]   pulse_w_in,
    output logic                   ena_out,
    output logic                   start_conv_out,
    input  logic                   ndecision_finish_in,
    input  logic [RESULT_W-1:0]    result_in,
    output logic [RESULT_W-1:0]    result_out,
    output logic                   result_valid_out,
    input  logic                   result_ready_in,
    output logic                   overrun_out,
`ifdef ADC_CONV_TIMEOUT_EN
    output logic                   timeout_err_out,
`endif
    output logic                   busy_out,
    input  logic                   cfg_dly_en_in,
    input  logic [DLY_SHORT_W-1:0] cfg_dly1_in,
    input  logic [DLY_SHORT_W-1:0] cfg_dly2_in,
    input  logic [DLY_SHORT_W-1:0] cfg_dly3_in,
    input  logic [DLY_LONG_W-1:0]  cfg_dly4_in,
    output logic                   enable_dlycontrol_out,
    output logic [DLY_SHORT_W-1:0] dlycontrol1_out,
    output logic [DLY_SHORT_W-1:0] dlycontrol2_out,
    output logic [DLY_SHORT_W-1:0] dlycontrol3_out,
    output logic [DLY_LONG_W-1:0]  dlycontrol4_out
);

    state_t                   state_q, state_d;
    logic [PULSE_W_W-1:0]     pulse_cnt_q, pulse_cnt_d;
    logic [PERIOD_W-1:0]      per_cnt_q, per_cnt_d;
    logic                     ena_q, ena_d;
    logic                     start_q, start_d;
    logic [RESULT_W-1:0]      result_q, result_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic                     dly_en_q, dly_en_d;
    logic [DLY_SHORT_W-1:0]   dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
    logic [DLY_LONG_W-1:0]    dly4_q, dly4_d;
    logic                     tick;
    logic                     done_fall;
    logic                     capture;
    logic                     tmo_hit;

    adc_sync_edge u_sync_edge (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .async_n_in (ndecision_finish_in),
        .fall_out   (done_fall)
    );

    // Periodic trigger: counts 0..period_in-1 and ticks on the last count.
    always_comb begin
        per_cnt_d = per_cnt_q;
        tick      = 1'b0;
        if (!periodic_en_in || period_in == '0) begin
            per_cnt_d = '0;
        end else if (per_cnt_q >= period_in - PERIOD_W'(1)) begin
            tick      = 1'b1;
            per_cnt_d = '0;
        end else begin
            per_cnt_d = per_cnt_q + PERIOD_W'(1);
        end
    end

`ifdef ADC_CONV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;

    always_comb begin
        tmo_cnt_d = (state_q == ST_WAIT) ? tmo_cnt_q + TMO_W'(1) : '0;
        tmo_hit   = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
        tmo_err_d = tmo_err_q | (tmo_hit & ~done_fall);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err_out = tmo_err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sw_start_in || tick) state_d = ST_ARM;
            end
            ST_ARM: begin
                // Width is latched here so changes during the pulse are ignored.
                pulse_cnt_d = (pulse_w_in == '0) ? PULSE_W_W'(1) : pulse_w_in;
                state_d     = ST_PULSE;
            end
            ST_PULSE: begin
                if (pulse_cnt_q <= PULSE_W_W'(1)) state_d = ST_WAIT;
                else pulse_cnt_d = pulse_cnt_q - PULSE_W_W'(1);
            end
            ST_WAIT: begin
                if (done_fall) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ena_d   = (state_d == ST_ARM) || (state_d == ST_PULSE) || (state_d == ST_WAIT);
        start_d = (state_d == ST_PULSE);

        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (capture) begin
            result_d = result_in;
            valid_d  = 1'b1;
            if (valid_q && !result_ready_in) overrun_d = 1'b1;
        end else if (valid_q && result_ready_in) begin
            valid_d = 1'b0;
        end

        dly_en_d = dly_en_q;
        dly1_d   = dly1_q;
        dly2_d   = dly2_q;
        dly3_d   = dly3_q;
        dly4_d   = dly4_q;
        // Delay settings track cfg only while idle so a conversion sees fixed values.
        if (state_d == ST_IDLE) begin
            dly_en_d = cfg_dly_en_in;
            dly1_d   = cfg_dly1_in;
            dly2_d   = cfg_dly2_in;
            dly3_d   = cfg_dly3_in;
            dly4_d   = cfg_dly4_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            pulse_cnt_q <= '0;
            per_cnt_q   <= '0;
            ena_q       <= 1'b0;
            start_q     <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            dly_en_q    <= 1'b0;
            dly1_q      <= '0;
            dly2_q      <= '0;
            dly3_q      <= '0;
            dly4_q      <= '0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            per_cnt_q   <= per_cnt_d;
            ena_q       <= ena_d;
            start_q     <= start_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            dly_en_q    <= dly_en_d;
            dly1_q      <= dly1_d;
            dly2_q      <= dly2_d;
            dly3_q      <= dly3_d;
            dly4_q      <= dly4_d;
        end
    end

    assign ena_out               = ena_q;
    assign start_conv_out        = start_q;
    assign result_out            = result_q;
    assign result_valid_out      = valid_q;
    assign overrun_out           = overrun_q;
    assign busy_out              = (state_q != ST_IDLE);
    assign enable_dlycontrol_out = dly_en_q;
    assign dlycontrol1_out       = dly1_q;
    assign dlycontrol2_out       = dly2_q;
    assign dlycontrol3_out       = dly3_q;
    assign dlycontrol4_out       = dly4_q;

endmodule
